// File: rtl/ctl_que_fetch_pkg.sv
// Shared definitions for the control-queue fetch engine: entry layout, opcodes, FSM encoding
// and small helpers used by the top level.
package ctl_que_fetch_pkg;

    localparam int unsigned CTLQ_ADDR_W = 48;
    localparam int unsigned CTLQ_ENT_W  = 64;
    localparam int unsigned CTLQ_UNIT_W = 8;

    localparam int unsigned CTLQ_OP_LSB   = 56;
    localparam int unsigned CTLQ_UNIT_LSB = 48;
    localparam int unsigned CTLQ_PAY_LSB  = 0;
    localparam int unsigned CTLQ_PAY_W    = 48;

    localparam logic [7:0] CTLQ_OP_END  = 8'h00;
    localparam logic [7:0] CTLQ_OP_CALL = 8'h01;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef struct packed {
        logic [7:0]            op;
        logic [CTLQ_UNIT_W-1:0] unit;
        logic [CTLQ_PAY_W-1:0]  payload;
    } ctlq_ent_t;

    typedef enum logic [1:0] {
        HeadNop,
        HeadCall,
        HeadBad,
        HeadEnd
    } ctlq_head_e;

    // Entry byte address; the 48-bit sum deliberately drops any carry.
    function automatic logic [CTLQ_ADDR_W-1:0] ctlq_ent_addr(
        input logic [CTLQ_ADDR_W-1:0] base,
        input logic [CTLQ_ADDR_W-1:0] idx
    );
        return base + {idx[CTLQ_ADDR_W-4:0], 3'b000};
    endfunction

    function automatic ctlq_head_e ctlq_classify(
        input ctlq_ent_t              ent,
        input logic [CTLQ_UNIT_W-1:0] units
    );
        if (ent.op == CTLQ_OP_END) return HeadEnd;
        if (ent.op != CTLQ_OP_CALL) return HeadNop;
        return (ent.unit < units) ? HeadCall : HeadBad;
    endfunction

endpackage

// File: rtl/ctl_que_fetch_if.sv
// Memory-read and unit-command channels of the control-queue fetch engine.
interface ctl_que_fetch_if;
    import ctl_que_fetch_pkg::*;

    logic                   mif_rd_vld;
    logic [CTLQ_ADDR_W-1:0] mif_rd_addr;
    logic                   mif_rd_rdy;
    logic                   mif_rsp_vld;
    logic [CTLQ_ENT_W-1:0]  mif_rsp_data;
    logic                   cmd_vld;
    logic [CTLQ_UNIT_W-1:0] cmd_unit;
    logic [CTLQ_PAY_W-1:0]  cmd_data;
    logic                   cmd_rdy;

    modport master (
        output mif_rd_vld, mif_rd_addr,
        input  mif_rd_rdy, mif_rsp_vld, mif_rsp_data,
        output cmd_vld, cmd_unit, cmd_data,
        input  cmd_rdy
    );

    modport slave (
        input  mif_rd_vld, mif_rd_addr,
        output mif_rd_rdy, mif_rsp_vld, mif_rsp_data,
        input  cmd_vld, cmd_unit, cmd_data,
        output cmd_rdy
    );

endinterface

// File: rtl/ctlq_rsp_fifo.sv
// Registered response FIFO for the fetch engine; flush empties it in one cycle and wins over push.
module ctlq_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/ctl_que_fetch.sv
// Control-queue fetch engine: reads 64-bit entries from host memory and forwards CALLs to units.
// Optional build macro CTLQ_PERF_EN adds the perf_cmd_cnt accepted-command counter output.
module ctl_que_fetch
    import ctl_que_fetch_pkg::*;
#(
    parameter int unsigned QUE_DEPTH = 512,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   reset_top,
    input  logic [CTLQ_ADDR_W-1:0] ctlQueBase,
    input  logic [CTLQ_UNIT_W-1:0] num_units,
    output logic                   busy,
    output logic                   err_unit,
`ifdef CTLQ_PERF_EN
    output logic [31:0]            perf_cmd_cnt,
`endif
    ctl_que_fetch_if.master        bus
);

    localparam int unsigned IW = $clog2(QUE_DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTST) + 1;

    logic [1:0]             state_q, state_d;
    logic [CTLQ_ADDR_W-1:0] base_q, base_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          credits_q, credits_d;
    logic                   err_unit_q, err_unit_d;

    logic [CTLQ_ENT_W-1:0]  fifo_head;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_cnt;
    logic                   fifo_push, fifo_pop, fifo_flush;

    ctlq_ent_t              head_ent;
    ctlq_head_e             head_kind;
    logic                   head_live;
    logic                   rd_acc, cmd_acc, end_pop;

    assign head_ent  = fifo_head;
    assign head_kind = ctlq_classify(head_ent, num_units);
    assign head_live = (state_q == ST_FETCH) && !fifo_empty;

    // Credits cover buffered responses too, so the FIFO can never be pushed while full.
    assign bus.mif_rd_vld  = (state_q == ST_FETCH) && (credits_q < CW'(MAX_OUTST));
    assign bus.mif_rd_addr = ctlq_ent_addr(base_q, CTLQ_ADDR_W'(idx_q));
    assign bus.cmd_vld     = head_live && (head_kind == HeadCall);
    assign bus.cmd_unit    = bus.cmd_vld ? head_ent.unit : '0;
    assign bus.cmd_data    = bus.cmd_vld ? head_ent.payload : '0;

    assign rd_acc  = bus.mif_rd_vld && bus.mif_rd_rdy;
    assign cmd_acc = bus.cmd_vld && bus.cmd_rdy;
    assign end_pop = head_live && (head_kind == HeadEnd);

    assign fifo_pop   = head_live && ((head_kind == HeadCall) ? bus.cmd_rdy : 1'b1);
    assign fifo_push  = bus.mif_rsp_vld && (state_q == ST_FETCH) && !end_pop && !reset_top;
    assign fifo_flush = end_pop || reset_top;

    ctlq_rsp_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (CTLQ_ENT_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (bus.mif_rsp_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        credits_d  = credits_q;
        err_unit_d = err_unit_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    base_d     = ctlQueBase;
                    idx_d      = '0;
                    err_unit_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (rd_acc) begin
                    idx_d = idx_q + IW'(1);
                end
                if (head_live && (head_kind == HeadBad)) begin
                    err_unit_d = 1'b1;
                end
                if (end_pop) begin
                    // The END entry, everything behind it and any response landing now are dropped.
                    credits_d = credits_q + CW'(rd_acc) - fifo_cnt - CW'(bus.mif_rsp_vld);
                    state_d   = (credits_d == '0) ? ST_IDLE : ST_DRAIN;
                end else begin
                    credits_d = credits_q + CW'(rd_acc) - CW'(fifo_pop);
                end
            end
            ST_DRAIN: begin
                credits_d = credits_q - CW'(bus.mif_rsp_vld);
                if (credits_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reset_top) begin
            state_d    = ST_IDLE;
            base_d     = '0;
            idx_d      = '0;
            credits_d  = '0;
            err_unit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            idx_q      <= '0;
            credits_q  <= '0;
            err_unit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            credits_q  <= credits_d;
            err_unit_q <= err_unit_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign err_unit = err_unit_q;

`ifdef CTLQ_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (reset_top || ((state_q == ST_IDLE) && start)) begin
            perf_cnt_d = '0;
        end else if (cmd_acc && (perf_cnt_q != '1)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_cmd_cnt = perf_cnt_q;
`endif

endmodule

// File: doc/ctl_que_fetch.md
# ctl_que_fetch

Control-queue fetch engine sitting directly downstream of the dispatch block. On the dispatch `start` pulse it reads 64-bit control entries from host memory starting at `ctlQueBase`, forwards call entries to the personality units over a valid/ready command channel, and stops at the first end-of-queue entry. It drives the `busy` input of dispatch, which holds dispatch in its BUSY state until the queue is exhausted and all reads have drained.

## Interface
Parameters:
- QUE_DEPTH, 512: entries in the ring before the read index wraps; power of two.
- MAX_OUTST, 4: maximum read credits (outstanding requests plus buffered responses); power of two, 2..16.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse from dispatch; begins a fetch pass.
- reset_top  in  1  dispatch idle indicator; while high, forces IDLE and clears state exactly like `reset`.
- ctlQueBase  in  48  byte address of entry 0; 8-byte aligned; sampled on `start`.
- num_units  in  8  number of valid unit indices.
- busy  out  1  high from the cycle after `start` until the pass fully completes.
- mif_rd_vld  out  1  memory read request valid.
- mif_rd_addr  out  48  read byte address.
- mif_rd_rdy  in  1  request accepted when vld && rdy.
- mif_rsp_vld  in  1  read response valid; responses return in request order.
- mif_rsp_data  in  64  read response data.
- cmd_vld  out  1  unit command valid.
- cmd_unit  out  8  destination unit index.
- cmd_data  out  48  command payload.
- cmd_rdy  in  1  command accepted when vld && rdy.
- err_unit  out  1  sticky: a call entry named a unit ≥ num_units; cleared by `start`, reset, or reset_top.

## Operation
- Entry format: [63:56] opcode, [55:48] unit, [47:0] payload. Opcode 0x00 = END, 0x01 = CALL, any other = NOP (skipped).
- States: IDLE, FETCH, DRAIN.
- IDLE: busy=0, no requests. `start` → FETCH; latch base, idx=0, clear err_unit.
- FETCH: issue a read whenever credits < MAX_OUTST; address = base + (idx mod QUE_DEPTH)*8 (48-bit add, carry discarded); idx increments on each accepted request. Responses enter the response FIFO. Head handling: CALL with unit < num_units → present on cmd channel, pop on cmd accept; CALL with bad unit → set err_unit, pop with no cmd; NOP → pop; END → pop, stop issuing, go to DRAIN.
- DRAIN: no new requests; returning responses and FIFO contents discarded; when credits return to 0 → IDLE.
- Credit count = requests accepted but not yet popped (outstanding + buffered), so the FIFO (depth MAX_OUTST) never overflows; mif_rsp_vld has no backpressure.
- `start` while not IDLE is ignored.
- reset or reset_top mid-pass: immediate IDLE, credits=0, FIFO flushed, err_unit=0; late responses arriving afterwards are dropped.

## Timing
- Reset values: busy=0, mif_rd_vld=0, cmd_vld=0, err_unit=0, mif_rd_addr=0, cmd_unit=0, cmd_data=0.
- `start` sampled in cycle T: busy=1 and first mif_rd_vld (addr=base) in T+1.
- Response in cycle R → cmd_vld earliest in R+1 (FIFO registered).
- Peak rate: one request and one command per cycle.
- END popped in cycle E with no credits outstanding: busy=0 in E+1. Otherwise busy falls the cycle after the last credit is returned.
- mif_rd_addr and cmd_* are held stable while valid and not ready.

## Configuration
- CTLQ_PERF_EN defined: adds output perf_cmd_cnt[31:0], counting accepted commands; cleared on `start`/reset/reset_top; saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package: opcode constants (CTLQ_OP_END, CTLQ_OP_CALL), entry field offsets/widths, state encoding.
- One sub-module: ctlq_rsp_fifo, synchronous FIFO, 64-bit wide, depth MAX_OUTST, with flush input.

## Test plan
- Base 0x1000, queue {CALL u2 p=0xAB, END}, cmd_rdy=1 → one cmd (unit 2, data 0xAB), reads at 0x1000/0x1008.., busy falls after the last response drains.
- Queue of 10 CALLs, cmd_rdy held low → at most 4 outstanding reads, no FIFO overflow; release rdy → 10 cmds in order.
- QUE_DEPTH=4, END at entry 5 → addresses base+0..+24 then wrap to base+0.
- CALL unit 9 with num_units=8 → no cmd, err_unit=1, pass completes.
- reset_top asserted mid-FETCH with 3 outstanding → busy=0 next cycle, late responses produce no cmd.
- NOP, CALL u0, END → single cmd; with CTLQ_PERF_EN perf_cmd_cnt=1.
